// File: rtl/jelly_video_sync_gen_core.sv
// Free-running video timing generator: vsync/hsync/DE from shadow-latched frame geometry.
// Optional macro JELLY_VIDEO_SYNC_GEN_OUT_COUNT_EN adds registered h/v count outputs.
module jelly_video_sync_gen_core #(
  parameter int H_COUNT_WIDTH = 14,
  parameter int V_COUNT_WIDTH = 14
) (
  input  logic                     reset_n,
  input  logic                     clk,

  input  logic                     enable,
  output logic                     busy,
  output logic                     update_trig,

  input  logic [H_COUNT_WIDTH-1:0] param_htotal,
  input  logic [H_COUNT_WIDTH-1:0] param_hsync_start,
  input  logic [H_COUNT_WIDTH-1:0] param_hsync_end,
  input  logic [H_COUNT_WIDTH-1:0] param_hde_start,
  input  logic [H_COUNT_WIDTH-1:0] param_hsize,
  input  logic [V_COUNT_WIDTH-1:0] param_vtotal,
  input  logic [V_COUNT_WIDTH-1:0] param_vsync_start,
  input  logic [V_COUNT_WIDTH-1:0] param_vsync_end,
  input  logic [V_COUNT_WIDTH-1:0] param_vde_start,
  input  logic [V_COUNT_WIDTH-1:0] param_vsize,
  input  logic                     param_hpol,
  input  logic                     param_vpol,

  output logic                     out_vsync,
  output logic                     out_hsync,
`ifdef JELLY_VIDEO_SYNC_GEN_OUT_COUNT_EN
  output logic                     out_de,
  output logic [H_COUNT_WIDTH-1:0] out_h_count,
  output logic [V_COUNT_WIDTH-1:0] out_v_count
`else
  output logic                     out_de
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [H_COUNT_WIDTH-1:0] r_h;
  logic [V_COUNT_WIDTH-1:0] r_v;
  logic [H_COUNT_WIDTH-1:0] w_next_h;
  logic [V_COUNT_WIDTH-1:0] w_next_v;
  logic                     w_latch;

  logic [H_COUNT_WIDTH-1:0] r_htotal;
  logic [H_COUNT_WIDTH-1:0] r_hsync_start;
  logic [H_COUNT_WIDTH-1:0] r_hsync_end;
  logic [H_COUNT_WIDTH-1:0] r_hde_start;
  logic [H_COUNT_WIDTH-1:0] r_hsize;
  logic [V_COUNT_WIDTH-1:0] r_vtotal;
  logic [V_COUNT_WIDTH-1:0] r_vsync_start;
  logic [V_COUNT_WIDTH-1:0] r_vsync_end;
  logic [V_COUNT_WIDTH-1:0] r_vde_start;
  logic [V_COUNT_WIDTH-1:0] r_vsize;
  logic                     r_hpol;
  logic                     r_vpol;

  logic                     r_update_trig;
  logic                     r_out_hsync;
  logic                     r_out_vsync;
  logic                     r_out_de;

  logic [H_COUNT_WIDTH:0]   w_h_inc;
  logic [V_COUNT_WIDTH:0]   w_v_inc;
  logic [H_COUNT_WIDTH:0]   w_h_de_end;
  logic [V_COUNT_WIDTH:0]   w_v_de_end;
  logic                     w_h_last;
  logic                     w_v_last;
  logic                     w_hs_act;
  logic                     w_vs_act;
  logic                     w_h_de;
  logic                     w_v_de;
  logic                     w_next_hsync;
  logic                     w_next_vsync;
  logic                     w_next_de;

  // Wrap detection and active-region decode, all at width+1 so start+size never wraps
  always_comb begin
    w_h_inc    = {1'b0, r_h} + {{H_COUNT_WIDTH{1'b0}}, 1'b1};
    w_v_inc    = {1'b0, r_v} + {{V_COUNT_WIDTH{1'b0}}, 1'b1};
    w_h_last   = (w_h_inc >= {1'b0, r_htotal});
    w_v_last   = (w_v_inc >= {1'b0, r_vtotal});
    w_h_de_end = {1'b0, r_hde_start} + {1'b0, r_hsize};
    w_v_de_end = {1'b0, r_vde_start} + {1'b0, r_vsize};
    w_hs_act   = (r_h >= r_hsync_start) && (r_h < r_hsync_end);
    w_vs_act   = (r_v >= r_vsync_start) && (r_v < r_vsync_end);
    w_h_de     = (r_h >= r_hde_start) && ({1'b0, r_h} < w_h_de_end);
    w_v_de     = (r_v >= r_vde_start) && ({1'b0, r_v} < w_v_de_end);
  end

  // Next state, next counters and shadow-latch request
  always_comb begin
    w_next_state = r_state;
    w_next_h     = r_h;
    w_next_v     = r_v;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_h = {H_COUNT_WIDTH{1'b0}};
        w_next_v = {V_COUNT_WIDTH{1'b0}};
        if (enable) begin
          w_next_state = ST_RUN;
          w_latch      = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_h_last) begin
          w_next_h = {H_COUNT_WIDTH{1'b0}};
          if (w_v_last) begin
            w_next_v = {V_COUNT_WIDTH{1'b0}};
            if (enable) begin
              w_next_state = ST_RUN;
              w_latch      = 1'b1;
            end else begin
              w_next_state = ST_IDLE;
            end
          end else begin
            w_next_v = w_v_inc[V_COUNT_WIDTH-1:0];
          end
        end else begin
          w_next_h = w_h_inc[H_COUNT_WIDTH-1:0];
          w_next_v = r_v;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_h     = {H_COUNT_WIDTH{1'b0}};
        w_next_v     = {V_COUNT_WIDTH{1'b0}};
      end
    endcase
  end

  // IDLE drives inactive sync levels from the live polarity inputs
  always_comb begin
    if (r_state == ST_RUN) begin
      w_next_hsync = w_hs_act ^ r_hpol;
      w_next_vsync = w_vs_act ^ r_vpol;
      w_next_de    = w_h_de & w_v_de;
    end else begin
      w_next_hsync = param_hpol;
      w_next_vsync = param_vpol;
      w_next_de    = 1'b0;
    end
  end

  // State, counters and update pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_h           <= {H_COUNT_WIDTH{1'b0}};
      r_v           <= {V_COUNT_WIDTH{1'b0}};
      r_update_trig <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_h           <= w_next_h;
      r_v           <= w_next_v;
      r_update_trig <= w_latch;
    end
  end

  // Shadow geometry registers, loaded only at frame boundaries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_htotal      <= {H_COUNT_WIDTH{1'b0}};
      r_hsync_start <= {H_COUNT_WIDTH{1'b0}};
      r_hsync_end   <= {H_COUNT_WIDTH{1'b0}};
      r_hde_start   <= {H_COUNT_WIDTH{1'b0}};
      r_hsize       <= {H_COUNT_WIDTH{1'b0}};
      r_vtotal      <= {V_COUNT_WIDTH{1'b0}};
      r_vsync_start <= {V_COUNT_WIDTH{1'b0}};
      r_vsync_end   <= {V_COUNT_WIDTH{1'b0}};
      r_vde_start   <= {V_COUNT_WIDTH{1'b0}};
      r_vsize       <= {V_COUNT_WIDTH{1'b0}};
      r_hpol        <= 1'b0;
      r_vpol        <= 1'b0;
    end else if (w_latch) begin
      r_htotal      <= param_htotal;
      r_hsync_start <= param_hsync_start;
      r_hsync_end   <= param_hsync_end;
      r_hde_start   <= param_hde_start;
      r_hsize       <= param_hsize;
      r_vtotal      <= param_vtotal;
      r_vsync_start <= param_vsync_start;
      r_vsync_end   <= param_vsync_end;
      r_vde_start   <= param_vde_start;
      r_vsize       <= param_vsize;
      r_hpol        <= param_hpol;
      r_vpol        <= param_vpol;
    end
  end

  // Timing output registers, one cycle behind the counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_hsync <= 1'b0;
      r_out_vsync <= 1'b0;
      r_out_de    <= 1'b0;
    end else begin
      r_out_hsync <= w_next_hsync;
      r_out_vsync <= w_next_vsync;
      r_out_de    <= w_next_de;
    end
  end

`ifdef JELLY_VIDEO_SYNC_GEN_OUT_COUNT_EN
  logic [H_COUNT_WIDTH-1:0] r_out_h_count;
  logic [V_COUNT_WIDTH-1:0] r_out_v_count;

  // Counter copies aligned with out_de
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_h_count <= {H_COUNT_WIDTH{1'b0}};
      r_out_v_count <= {V_COUNT_WIDTH{1'b0}};
    end else begin
      r_out_h_count <= r_h;
      r_out_v_count <= r_v;
    end
  end

  assign out_h_count = r_out_h_count;
  assign out_v_count = r_out_v_count;
`endif

  assign busy        = (r_state == ST_RUN);
  assign update_trig = r_update_trig;
  assign out_hsync   = r_out_hsync;
  assign out_vsync   = r_out_vsync;
  assign out_de      = r_out_de;

endmodule
